// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - instruction fetch front end with in-order buffer and redirect
module instr_fetch_unit #(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_PC   = '0,
    parameter int              IBUF_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_resp_valid,
    input  logic [XLEN-1:0] imem_resp_data,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc,
    output logic [6:0]      opcode,
    output logic [2:0]      funct3,
    output logic [6:0]      funct7,
    input  logic            pc_src,
    input  logic [XLEN-1:0] pc_target
);

    localparam int CW = $clog2(IBUF_DEPTH + 1);
    localparam int PW = (IBUF_DEPTH > 1) ? $clog2(IBUF_DEPTH) : 1;

    // Architectural state
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] resp_pc_q, resp_pc_d;
    logic [CW-1:0]   outstanding_q, outstanding_d;
    logic [CW-1:0]   drop_cnt_q, drop_cnt_d;
    logic [CW-1:0]   count_q, count_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;

    // Buffer storage: instruction word and its address per entry
    logic [XLEN-1:0] data_mem_q [IBUF_DEPTH];
    logic [XLEN-1:0] pcs_mem_q  [IBUF_DEPTH];

    // Event strobes for this cycle
    logic            fire;
    logic            resp_acc;
    logic            resp_drop;
    logic            push;
    logic            pop;
    logic [CW:0]     inflight;
    logic [CW-1:0]   outstanding_after_resp;
    logic [XLEN-1:0] target_aligned;
    logic [XLEN-1:0] head_data;
    logic [XLEN-1:0] head_pc;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(IBUF_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Masking rather than slicing keeps every target bit in use; the low two are forced to zero
    assign target_aligned = pc_target & ~XLEN'(3);

    // Requests are capped so that every in-flight word is guaranteed a buffer slot
    always_comb begin
        inflight       = {1'b0, outstanding_q} + {1'b0, count_q};
        imem_req_valid = ~rst & ~pc_src & (inflight < (CW + 1)'(IBUF_DEPTH));
        imem_req_addr  = pc_q;
        fire           = imem_req_valid & imem_req_ready;
    end

    // Response bookkeeping: stray responses with nothing outstanding are ignored, stale ones dropped
    always_comb begin
        resp_acc               = imem_resp_valid & (outstanding_q != '0);
        resp_drop              = resp_acc & (drop_cnt_q != '0);
        push                   = resp_acc & ~resp_drop & ~pc_src;
        pop                    = (count_q != '0) & instr_ready & ~pc_src;
        outstanding_after_resp = outstanding_q - CW'(resp_acc);
    end

    // Next-state logic; a redirect overrides every other event in the cycle
    always_comb begin
        pc_d          = pc_q;
        resp_pc_d     = resp_pc_q;
        outstanding_d = outstanding_after_resp + CW'(fire);
        drop_cnt_d    = drop_cnt_q;
        count_d       = count_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        if (pc_src) begin
            pc_d       = target_aligned;
            resp_pc_d  = target_aligned;
            // Everything still in flight belongs to the abandoned path
            drop_cnt_d = outstanding_after_resp;
            count_d    = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
        end else begin
            if (fire) begin
                pc_d = pc_q + XLEN'(4);
            end
            if (resp_drop) begin
                drop_cnt_d = drop_cnt_q - CW'(1);
            end
            if (push) begin
                resp_pc_d = resp_pc_q + XLEN'(4);
                wr_ptr_d  = ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    // Control state registers with immediate clear on reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q          <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
            count_q       <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
        end else begin
            pc_q          <= pc_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
            count_q       <= count_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
        end
    end

    // Buffer payload; contents are qualified by count so no reset is needed
    always_ff @(posedge clk) begin
        if (push) begin
            data_mem_q[wr_ptr_q] <= imem_resp_data;
            pcs_mem_q[wr_ptr_q]  <= resp_pc_q;
        end
    end

    // Head presentation; all fields read as zero while the buffer is empty
    always_comb begin
        instr_valid = (count_q != '0);
        head_data   = data_mem_q[rd_ptr_q];
        head_pc     = pcs_mem_q[rd_ptr_q];
        instr       = instr_valid ? head_data : '0;
        instr_pc    = instr_valid ? head_pc : '0;
        opcode      = instr[6:0];
        funct3      = instr[14:12];
        funct7      = instr[31:25];
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - self-checking bench for instr_fetch_unit
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready = 1'b1;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        pc_src = 1'b0;
    logic [31:0] pc_target = '0;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    bit cons_en  = 1'b0;
    bit mem_hold = 1'b0;
    int mem_lat  = 1;

    logic [31:0] exp_q[$];

    typedef struct {
        int          due;
        logic [31:0] addr;
    } pend_t;
    pend_t pq[$];

    instr_fetch_unit #(
        .XLEN(32),
        .RESET_PC(32'h0000_0000),
        .IBUF_DEPTH(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .imem_req_valid(imem_req_valid),
        .imem_req_addr(imem_req_addr),
        .imem_req_ready(imem_req_ready),
        .imem_resp_valid(imem_resp_valid),
        .imem_resp_data(imem_resp_data),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .instr(instr),
        .instr_pc(instr_pc),
        .opcode(opcode),
        .funct3(funct3),
        .funct7(funct7),
        .pc_src(pc_src),
        .pc_target(pc_target)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0)
            return 32'h0050_0093;
        else if (a == 32'h4)
            return 32'h00A0_0113;
        else
            return {a[24:0], 7'h33};
    endfunction

    // Memory model: responds in order mem_lat cycles after accept, unless held
    initial begin
        pend_t p;
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        forever begin
            @(negedge clk);
            cyc++;
            #1;
            if (rst) begin
                pq.delete();
                imem_resp_valid = 1'b0;
                imem_resp_data  = '0;
            end else begin
                if (!mem_hold && pq.size() > 0 && pq[0].due <= cyc) begin
                    imem_resp_valid = 1'b1;
                    imem_resp_data  = mem_word(pq[0].addr);
                    void'(pq.pop_front());
                end else begin
                    imem_resp_valid = 1'b0;
                    imem_resp_data  = '0;
                end
                if (imem_req_valid && imem_req_ready) begin
                    p.due  = cyc + mem_lat;
                    p.addr = imem_req_addr;
                    pq.push_back(p);
                end
            end
        end
    end

    // Consumer: takes a head only when one is expected, compares against the scoreboard
    initial begin
        logic [31:0] e;
        logic [31:0] w;
        instr_ready = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            instr_ready = cons_en && (exp_q.size() > 0) && !rst;
            #1;
            if (instr_valid && instr_ready) begin
                e = exp_q.pop_front();
                w = mem_word(e);
                checks++;
                if (instr_pc !== e) begin
                    errors++;
                    $display("FAIL cons_pc: got=%h exp=%h", instr_pc, e);
                end
                checks++;
                if (instr !== w) begin
                    errors++;
                    $display("FAIL cons_instr pc=%h: got=%h exp=%h", e, instr, w);
                end
                checks++;
                if (opcode !== w[6:0] || funct3 !== w[14:12] || funct7 !== w[31:25]) begin
                    errors++;
                    $display("FAIL cons_fields pc=%h: got=%h/%h/%h exp=%h/%h/%h",
                             e, opcode, funct3, funct7, w[6:0], w[14:12], w[31:25]);
                end
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst      = 1'b1;
        cons_en  = 1'b0;
        pc_src   = 1'b0;
        mem_hold = 1'b0;
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_drain(input int budget, input string name);
        int n = 0;
        while (exp_q.size() > 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: remaining=%0d exp=0", name, exp_q.size());
        end
        cons_en = 1'b0;
        exp_q.delete();
    endtask

    task automatic test_reset();
        @(negedge clk);
        #3;
        checks++;
        if (imem_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_req_valid: got=%b exp=0", imem_req_valid);
        end
        checks++;
        if (imem_req_addr !== 32'h0) begin
            errors++;
            $display("FAIL rst_req_addr: got=%h exp=0", imem_req_addr);
        end
        checks++;
        if (instr_valid !== 1'b0 || instr !== 32'h0 || instr_pc !== 32'h0) begin
            errors++;
            $display("FAIL rst_head: got=%b/%h/%h exp=0/0/0", instr_valid, instr, instr_pc);
        end
        checks++;
        if (opcode !== 7'h0 || funct3 !== 3'h0 || funct7 !== 7'h0) begin
            errors++;
            $display("FAIL rst_fields: got=%h/%h/%h exp=0/0/0", opcode, funct3, funct7);
        end
        @(negedge clk);
        rst = 1'b0;
        #3;
        checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin
            errors++;
            $display("FAIL rel_req: got=%b/%h exp=1/00000000", imem_req_valid, imem_req_addr);
        end
        checks++;
        if (instr_valid !== 1'b0 || instr !== 32'h0) begin
            errors++;
            $display("FAIL rel_head: got=%b/%h exp=0/0", instr_valid, instr);
        end
        @(negedge clk);
        #3;
        checks++;
        if (instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL lat_cycle1: got=%b exp=0", instr_valid);
        end
        @(negedge clk);
        #3;
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'h0 || opcode !== 7'h13) begin
            errors++;
            $display("FAIL lat_cycle2: got=%b/%h/%h exp=1/0/13", instr_valid, instr_pc, opcode);
        end
    endtask

    task automatic test_sequence();
        do_reset();
        for (int i = 0; i < 8; i++) exp_q.push_back(32'(i * 4));
        cons_en = 1'b1;
        wait_drain(60, "seq");
    endtask

    task automatic test_stall();
        do_reset();
        repeat (6) @(negedge clk);
        #3;
        checks++;
        if (imem_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_req_valid: got=%b exp=0", imem_req_valid);
        end
        checks++;
        if (imem_req_addr !== 32'h8) begin
            errors++;
            $display("FAIL stall_req_addr: got=%h exp=00000008", imem_req_addr);
        end
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'h0) begin
            errors++;
            $display("FAIL stall_head: got=%b/%h exp=1/00000000", instr_valid, instr_pc);
        end
        @(negedge clk);
        for (int i = 0; i < 6; i++) exp_q.push_back(32'(i * 4));
        cons_en = 1'b1;
        wait_drain(60, "stall");
    endtask

    task automatic test_redirect();
        do_reset();
        mem_hold = 1'b1;
        repeat (4) @(negedge clk);
        #3;
        checks++;
        if (imem_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL redir_cap: got=%b exp=0", imem_req_valid);
        end
        @(negedge clk);
        pc_src    = 1'b1;
        pc_target = 32'h0000_0103;
        @(negedge clk);
        pc_src   = 1'b0;
        mem_hold = 1'b0;
        #3;
        checks++;
        if (imem_req_addr !== 32'h100) begin
            errors++;
            $display("FAIL redir_addr: got=%h exp=00000100", imem_req_addr);
        end
        checks++;
        if (instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL redir_flush: got=%b exp=0", instr_valid);
        end
        exp_q.push_back(32'h100);
        exp_q.push_back(32'h104);
        exp_q.push_back(32'h108);
        cons_en = 1'b1;
        wait_drain(60, "redir");
    endtask

    task automatic test_coincident();
        do_reset();
        mem_hold = 1'b1;
        repeat (4) @(negedge clk);
        mem_hold  = 1'b0;
        pc_src    = 1'b1;
        pc_target = 32'h0000_0200;
        #3;
        checks++;
        if (imem_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL coin_req_gate: got=%b exp=0", imem_req_valid);
        end
        @(negedge clk);
        pc_src = 1'b0;
        exp_q.push_back(32'h200);
        exp_q.push_back(32'h204);
        exp_q.push_back(32'h208);
        cons_en = 1'b1;
        wait_drain(60, "coin");
    endtask

    task automatic test_wrap();
        do_reset();
        pc_src    = 1'b1;
        pc_target = 32'hFFFF_FFFF;
        #3;
        checks++;
        if (imem_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL wrap_req_gate: got=%b exp=0", imem_req_valid);
        end
        @(negedge clk);
        pc_src = 1'b0;
        #3;
        checks++;
        if (imem_req_addr !== 32'hFFFF_FFFC || imem_req_valid !== 1'b1) begin
            errors++;
            $display("FAIL wrap_addr: got=%b/%h exp=1/fffffffc", imem_req_valid, imem_req_addr);
        end
        exp_q.push_back(32'hFFFF_FFFC);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h4);
        cons_en = 1'b1;
        wait_drain(60, "wrap");
    endtask

    task automatic test_reset_mid();
        do_reset();
        repeat (6) @(negedge clk);
        #3;
        checks++;
        if (instr_valid !== 1'b1) begin
            errors++;
            $display("FAIL mid_setup: got=%b exp=1", instr_valid);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (instr_valid !== 1'b0 || imem_req_valid !== 1'b0 || instr !== 32'h0) begin
            errors++;
            $display("FAIL mid_rst: got=%b/%b/%h exp=0/0/0", instr_valid, imem_req_valid, instr);
        end
        @(negedge clk);
        rst = 1'b0;
        #3;
        checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin
            errors++;
            $display("FAIL mid_restart: got=%b/%h exp=1/00000000", imem_req_valid, imem_req_addr);
        end
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h4);
        exp_q.push_back(32'h8);
        cons_en = 1'b1;
        wait_drain(60, "mid");
    endtask

    initial begin
        test_reset();
        test_sequence();
        test_stall();
        test_redirect();
        test_coincident();
        test_wrap();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
